cam_to_screen: RTL and testbench
================================

# cam_to_screen

Perspective-projection stage directly downstream of the camera-space transform. It accepts one camera-space point (x along u, y along v, depth along n) per handshake and rejects points closer than the near plane. For surviving points it computes 1/z with an iterative restoring divider, then applies the perspective divide and viewport scaling to produce integer pixel coordinates plus a visibility flag. It feeds the rasteriser/vertex buffer through a valid/ready output handshake.

## Interface
- CAM_WIDTH, 23: signed width of cam_x/cam_y/cam_z (fixed point, FRAC_BITS fractional).
- FRAC_BITS, 14: fractional bits of all fixed-point inputs and internal NDC values.
- NEAR, 4096: near-plane depth, raw fixed-point (0.25 at FRAC_BITS=14).
- SCREEN_W, 320: viewport width in pixels; HALF_W = SCREEN_W/2.
- SCREEN_H, 240: viewport height in pixels; HALF_H = SCREEN_H/2.
- PIX_WIDTH, 11: unsigned width of pixel outputs.
- clk_in  input  1  single clock, all logic on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- in_valid  input  1  point present on cam_* inputs.
- in_ready  output  1  block can accept a point.
- cam_x, cam_y, cam_z  input  CAM_WIDTH each  signed camera-space point.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- pix_x, pix_y  output  PIX_WIDTH each  screen coordinates, origin top-left.
- depth  output  CAM_WIDTH  registered copy of cam_z.
- visible  output  1  point in front of near plane and inside viewport.

## Operation
- FSM states: IDLE, DIV, MUL, SCALE, OUT. in_ready = (state==IDLE) and not in reset.
- IDLE: on in_valid&&in_ready capture cam_x, cam_y, cam_z. If signed cam_z < NEAR (includes zero and negative), set visible=0, pix_x=pix_y=0, depth=cam_z, go to OUT. Otherwise go to DIV.
- DIV: unsigned restoring divide of 2^(2*FRAC_BITS) by cam_z, one quotient bit per cycle, MSB first, 2*FRAC_BITS+1 cycles. Result recip = floor(2^(2F)/cam_z), Q.F format; because cam_z>=NEAR, recip <= 2^(2F)/NEAR and needs no saturation.
- MUL: ndc_x = (cam_x*recip)>>>F and ndc_y = (cam_y*recip)>>>F. Products are full width (CAM_WIDTH+F+3 bits) with an arithmetic shift, so rounding is floor.
- SCALE: sx = HALF_W + ((ndc_x*HALF_W)>>>F) and sy = HALF_H - ((ndc_y*HALF_H)>>>F), both at full width, no truncation before the compare.
  - visible = (0<=sx<SCREEN_W) && (0<=sy<SCREEN_H).
  - If visible, pix_x=sx[PIX_WIDTH-1:0] and pix_y=sy[PIX_WIDTH-1:0]; else pix_x=pix_y=0.
  - depth=cam_z. Go to OUT.
- OUT: out_valid=1. Outputs stay stable until out_valid&&out_ready, then go to IDLE. in_ready stays low throughout OUT, so there is no overlap between points.

## Timing
- Reset (rst_n_in low, async): state=IDLE, out_valid=0, pix_x=pix_y=0, depth=0, visible=0, in_ready=0 while asserted. in_ready rises in the first cycle after release.
- Reset mid-operation aborts immediately. No output is produced for the aborted point.
- Accept cycle = cycle 0. DIV occupies cycles 1..2F+1, MUL is cycle 2F+2, SCALE is cycle 2F+3. out_valid rises at cycle 2F+4 (cycle 32 at F=14).
- Culled point: out_valid rises at cycle 1.
- With out_ready held high, out_valid is high for exactly one cycle. in_ready returns the next cycle, giving a minimum accept-to-accept interval of 2F+5 cycles.
- out_ready low: hold all outputs with out_valid=1 indefinitely. out_ready arriving early has no effect outside OUT.
- in_valid outside IDLE is ignored, and inputs are not sampled then.

## Test plan
- Reset defaults: assert rst_n_in asynchronously mid-cycle -> all outputs 0 at once; in_ready=0 during reset and 1 one cycle after release.
- Centre point: cam=(0,0,16384) -> at cycle 32, pix=(160,120), visible=1, depth=16384, out_valid one cycle with out_ready=1.
- Divide and scale: (8192,-8192,16384) -> pix=(240,180), visible=1. (16384,0,32768) -> recip=8192, pix=(240,120).
- Near cull: cam_z=2048, and separately cam_z=-16384 -> out_valid at cycle 1, visible=0, pix=(0,0), depth echoes cam_z.
- Off-screen: (32768,0,16384) -> sx=480 -> visible=0, pix=(0,0). Edge case (16384,0,16384) -> sx=320 -> visible=0. Edge case (16383,0,16384) -> sx=319 -> visible=1.
- Backpressure and abort: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, in_valid ignored. Separately, pulse rst_n_in low during DIV -> no out_valid for that point, and the next point processes normally.

Source files
------------

// File: rtl/cam_to_screen.sv
// Perspective projection of one camera-space point to viewport pixels:
// near-plane cull, 1/z by restoring division, perspective divide, viewport scale.
module cam_to_screen #(
   parameter int CAM_WIDTH = 23,
   parameter int FRAC_BITS = 14,
   parameter int NEAR      = 4096,
   parameter int SCREEN_W  = 320,
   parameter int SCREEN_H  = 240,
   parameter int PIX_WIDTH = 11
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CAM_WIDTH-1:0] cam_x,
   input  logic [CAM_WIDTH-1:0] cam_y,
   input  logic [CAM_WIDTH-1:0] cam_z,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PIX_WIDTH-1:0] pix_x,
   output logic [PIX_WIDTH-1:0] pix_y,
   output logic [CAM_WIDTH-1:0] depth,
   output logic                 visible
);

   localparam int HALF_W = SCREEN_W / 2;
   localparam int HALF_H = SCREEN_H / 2;
   localparam int PW     = CAM_WIDTH + FRAC_BITS + 3;
   localparam int QW     = 2 * FRAC_BITS + 1;
   localparam int CNTW   = $clog2(QW);
   localparam logic [CNTW-1:0]             LAST_STEP = CNTW'(QW - 1);
   localparam logic signed [CAM_WIDTH-1:0] NEAR_S    = CAM_WIDTH'(NEAR);

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_SCALE, S_OUT} state_t;

   state_t                 r_state;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [PIX_WIDTH-1:0]   r_pix_x;
   logic [PIX_WIDTH-1:0]   r_pix_y;
   logic [CAM_WIDTH-1:0]   r_depth;
   logic                   r_visible;
   logic [CNTW-1:0]        r_cnt;

   logic signed [CAM_WIDTH-1:0] r_x;
   logic signed [CAM_WIDTH-1:0] r_y;
   logic signed [CAM_WIDTH-1:0] r_z;
   logic [CAM_WIDTH-1:0]        r_rem;
   logic [QW-1:0]               r_quo;
   logic signed [PW-1:0]        r_ndc_x;
   logic signed [PW-1:0]        r_ndc_y;

   // Fixed-point multiply with arithmetic shift: rounds toward minus infinity.
   function automatic logic signed [PW-1:0] fx_mul_floor(input logic signed [PW-1:0] a,
                                                          input logic signed [PW-1:0] b);
      logic signed [PW-1:0] p;
      p = a * b;
      return p >>> FRAC_BITS;
   endfunction

   logic signed [CAM_WIDTH-1:0] w_cam_z_s;
   logic                        w_cull;
   logic                        w_accept;
   logic                        w_div_bit;
   logic [CAM_WIDTH:0]          w_rem_sh;
   logic [CAM_WIDTH:0]          w_z_ext;
   logic                        w_ge;
   logic [CAM_WIDTH-1:0]        w_rem_nx;
   logic signed [PW-1:0]        w_recip;
   logic signed [PW-1:0]        w_sx;
   logic signed [PW-1:0]        w_sy;
   logic                        w_vis;

   assign w_cam_z_s = cam_z;
   assign w_cull    = (w_cam_z_s < NEAR_S);
   assign w_accept  = (r_state == S_IDLE) && r_in_ready && in_valid;

   // Dividend is the single bit 2^(2F): only the first step shifts in a one.
   assign w_div_bit = (r_cnt == '0);
   assign w_rem_sh  = {r_rem, w_div_bit};
   assign w_z_ext   = {1'b0, r_z};
   assign w_ge      = (w_rem_sh >= w_z_ext);
   assign w_rem_nx  = w_ge ? CAM_WIDTH'(w_rem_sh - w_z_ext) : w_rem_sh[CAM_WIDTH-1:0];
   assign w_recip   = PW'(r_quo);

   assign w_sx  = PW'(HALF_W) + fx_mul_floor(r_ndc_x, PW'(HALF_W));
   assign w_sy  = PW'(HALF_H) - fx_mul_floor(r_ndc_y, PW'(HALF_H));
   assign w_vis = !w_sx[PW-1] && (w_sx < PW'(SCREEN_W)) &&
                  !w_sy[PW-1] && (w_sy < PW'(SCREEN_H));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_depth     <= '0;
         r_visible   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_cnt      <= '0;
                  if (w_cull) begin
                     r_visible   <= 1'b0;
                     r_pix_x     <= '0;
                     r_pix_y     <= '0;
                     r_depth     <= cam_z;
                     r_out_valid <= 1'b1;
                     r_state     <= S_OUT;
                  end else begin
                     r_state <= S_DIV;
                  end
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            S_DIV: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_STEP) r_state <= S_MUL;
            end
            S_MUL: r_state <= S_SCALE;
            S_SCALE: begin
               r_visible   <= w_vis;
               r_pix_x     <= w_vis ? w_sx[PIX_WIDTH-1:0] : '0;
               r_pix_y     <= w_vis ? w_sy[PIX_WIDTH-1:0] : '0;
               r_depth     <= r_z;
               r_out_valid <= 1'b1;
               r_state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; every accept reloads them.
   always_ff @(posedge clk_in) begin
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               r_x   <= cam_x;
               r_y   <= cam_y;
               r_z   <= cam_z;
               r_rem <= '0;
               r_quo <= '0;
            end
         end
         S_DIV: begin
            r_rem <= w_rem_nx;
            r_quo <= {r_quo[QW-2:0], w_ge};
         end
         S_MUL: begin
            r_ndc_x <= fx_mul_floor(PW'(r_x), w_recip);
            r_ndc_y <= fx_mul_floor(PW'(r_y), w_recip);
         end
         default: ;
      endcase
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign pix_x     = r_pix_x;
   assign pix_y     = r_pix_y;
   assign depth     = r_depth;
   assign visible   = r_visible;

endmodule

// File: tb/tb_cam_to_screen.sv
// Directed bench for cam_to_screen: reset, projection vectors, culling,
// viewport edges, backpressure, abort by reset and back-to-back throughput.
module tb_cam_to_screen;

   logic        clk_in    = 1'b0;
   logic        rst_n_in  = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [22:0] cam_x     = '0;
   logic [22:0] cam_y     = '0;
   logic [22:0] cam_z     = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic [22:0] depth;
   logic        visible;

   int vectors     = 0;
   int miscompares = 0;

   cam_to_screen dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .cam_x    (cam_x),
      .cam_y    (cam_y),
      .cam_z    (cam_z),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .depth    (depth),
      .visible  (visible)
   );

   always #5 clk_in = ~clk_in;

   // Drive one point and return cycles from accept to out_valid (-1 on timeout).
   task automatic send_point(input int x, input int y, input int z, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk_in); #1;
         w++;
      end
      cam_x    = 23'(x);
      cam_y    = 23'(y);
      cam_z    = 23'(z);
      in_valid = 1'b1;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk_in); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset;
      #2 rst_n_in = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || pix_x !== 11'd0 || pix_y !== 11'd0 || depth !== 23'd0 ||
          visible !== 1'b0 || in_ready !== 1'b0) begin
         $display("FAIL reset_outputs: got ov=%b px=%0d py=%0d d=%0d v=%b rdy=%b want all 0",
                  out_valid, pix_x, pix_y, depth, visible, in_ready);
         miscompares++;
      end
      repeat (3) @(posedge clk_in);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         $display("FAIL reset_ready_held: got %b want 0", in_ready);
         miscompares++;
      end
      #2 rst_n_in = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         $display("FAIL ready_at_release: got %b want 0", in_ready);
         miscompares++;
      end
      @(posedge clk_in); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         $display("FAIL ready_after_release: got %b want 1", in_ready);
         miscompares++;
      end
   endtask

   task automatic test_centre;
      int lat;
      out_ready = 1'b1;
      send_point(0, 0, 16384, lat);
      vectors++;
      if (lat !== 32 || pix_x !== 11'd160 || pix_y !== 11'd120 || visible !== 1'b1 ||
          depth !== 23'd16384) begin
         $display("FAIL centre: got lat=%0d px=%0d py=%0d v=%b d=%0d want lat=32 px=160 py=120 v=1 d=16384",
                  lat, pix_x, pix_y, visible, depth);
         miscompares++;
      end
      @(posedge clk_in); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL centre_one_cycle: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
         miscompares++;
      end
   endtask

   task automatic test_project;
      int tx[12] = '{8192, 16384, 16384, -1, 0, 16383, 32768, 16384, 0, 0, -16384, -16385};
      int ty[12] = '{-8192, 0, 16384, -1, 0, 0, 0, 0, -16384, 16384, 0, 0};
      int tz[12] = '{16384, 32768, 49152, 16384, 4096, 16384, 16384, 16384, 16384, 16384, 16384, 16384};
      int ex[12] = '{240, 240, 213, 159, 160, 319, 0, 0, 0, 160, 0, 0};
      int ey[12] = '{180, 120, 81, 121, 120, 120, 0, 0, 0, 0, 120, 0};
      int ev[12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send_point(tx[i], ty[i], tz[i], lat);
         vectors++;
         if (lat !== 32 || pix_x !== 11'(ex[i]) || pix_y !== 11'(ey[i]) ||
             visible !== 1'(ev[i]) || depth !== 23'(tz[i])) begin
            $display("FAIL project[%0d]: got lat=%0d px=%0d py=%0d v=%b d=%0d want lat=32 px=%0d py=%0d v=%0d d=%0d",
                     i, lat, pix_x, pix_y, visible, depth, ex[i], ey[i], ev[i], tz[i]);
            miscompares++;
         end
         @(posedge clk_in); #1;
      end
   endtask

   task automatic test_cull;
      int tx[4] = '{100, 5, 1, 7};
      int ty[4] = '{200, 5, 1, -7};
      int tz[4] = '{2048, -16384, 0, 4095};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_point(tx[i], ty[i], tz[i], lat);
         vectors++;
         if (lat !== 1 || pix_x !== 11'd0 || pix_y !== 11'd0 || visible !== 1'b0 ||
             depth !== 23'(tz[i])) begin
            $display("FAIL cull[%0d]: got lat=%0d px=%0d py=%0d v=%b d=%h want lat=1 px=0 py=0 v=0 d=%h",
                     i, lat, pix_x, pix_y, visible, depth, 23'(tz[i]));
            miscompares++;
         end
         @(posedge clk_in); #1;
         vectors++;
         if (out_valid !== 1'b0) begin
            $display("FAIL cull_one_cycle[%0d]: got ov=%b want 0", i, out_valid);
            miscompares++;
         end
      end
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      send_point(8192, -8192, 16384, lat);
      vectors++;
      if (lat !== 32 || pix_x !== 11'd240 || pix_y !== 11'd180 || visible !== 1'b1) begin
         $display("FAIL bp_result: got lat=%0d px=%0d py=%0d v=%b want lat=32 px=240 py=180 v=1",
                  lat, pix_x, pix_y, visible);
         miscompares++;
      end
      for (int c = 0; c < 10; c++) begin
         cam_x    = 23'(3000 + c);
         cam_y    = 23'(100);
         cam_z    = 23'(1000);
         in_valid = 1'b1;
         @(posedge clk_in); #1;
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || pix_x !== 11'd240 || pix_y !== 11'd180 ||
             visible !== 1'b1 || depth !== 23'd16384) begin
            $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b px=%0d py=%0d v=%b d=%0d want ov=1 rdy=0 px=240 py=180 v=1 d=16384",
                     c, out_valid, in_ready, pix_x, pix_y, visible, depth);
            miscompares++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk_in); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL bp_release: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
         miscompares++;
      end
   endtask

   task automatic test_async_reset;
      int lat;
      out_ready = 1'b0;
      send_point(8192, 8192, 16384, lat);
      #3 rst_n_in = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || pix_x !== 11'd0 || pix_y !== 11'd0 || depth !== 23'd0 ||
          visible !== 1'b0 || in_ready !== 1'b0) begin
         $display("FAIL async_reset: got ov=%b px=%0d py=%0d d=%0d v=%b rdy=%b want all 0",
                  out_valid, pix_x, pix_y, depth, visible, in_ready);
         miscompares++;
      end
      out_ready = 1'b1;
      @(posedge clk_in); #2;
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         $display("FAIL async_reset_ready: got %b want 1", in_ready);
         miscompares++;
      end
   endtask

   task automatic test_abort;
      int seen;
      int lat;
      out_ready = 1'b1;
      cam_x    = 23'(8192);
      cam_y    = 23'(0);
      cam_z    = 23'(16384);
      in_valid = 1'b1;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #2 rst_n_in = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk_in); #1;
         if (out_valid) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         $display("FAIL abort_no_output: got %0d out_valid cycles want 0", seen);
         miscompares++;
      end
      send_point(16384, 16384, 49152, lat);
      vectors++;
      if (lat !== 32 || pix_x !== 11'd213 || pix_y !== 11'd81 || visible !== 1'b1 ||
          depth !== 23'd49152) begin
         $display("FAIL abort_next_point: got lat=%0d px=%0d py=%0d v=%b d=%0d want lat=32 px=213 py=81 v=1 d=49152",
                  lat, pix_x, pix_y, visible, depth);
         miscompares++;
      end
      @(posedge clk_in); #1;
   endtask

   task automatic test_back_to_back;
      int acc[$];
      int outs;
      int badpix;
      int w;
      out_ready = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk_in); #1;
         w++;
      end
      cam_x    = 23'(16384);
      cam_y    = 23'(0);
      cam_z    = 23'(32768);
      in_valid = 1'b1;
      outs   = 0;
      badpix = 0;
      for (int c = 0; c < 70; c++) begin
         if (in_valid && in_ready) acc.push_back(c);
         if (out_valid) begin
            outs++;
            if (pix_x !== 11'd240 || pix_y !== 11'd120 || visible !== 1'b1) badpix++;
         end
         @(posedge clk_in); #1;
      end
      in_valid = 1'b0;
      vectors++;
      if (acc.size() != 3 || acc[1] - acc[0] != 33 || acc[2] - acc[1] != 33) begin
         $display("FAIL b2b_interval: got %0d accepts, first gaps %0d/%0d want 3 accepts 33 apart",
                  acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1,
                  (acc.size() > 2) ? acc[2] - acc[1] : -1);
         miscompares++;
      end
      vectors++;
      if (outs !== 2 || badpix !== 0) begin
         $display("FAIL b2b_outputs: got %0d outputs (%0d wrong) want 2 outputs px=240 py=120",
                  outs, badpix);
         miscompares++;
      end
      repeat (40) @(posedge clk_in);
      #1;
   endtask

   initial begin
      test_reset();
      test_centre();
      test_project();
      test_cull();
      test_backpressure();
      test_async_reset();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
